chs_conf_sequencer: RTL and testbench
=====================================

Name: chs_conf_sequencer

Overview:
- Shares the single channel-configuration word `chs_conf[7:0]` between N_REQ room requesters. The word feeds the mode/power decoder; chs_mode = bit 7, chs_power = bits 3:0.
- Arbitrates requests round-robin and ramps power one step per tick toward the granted target, so a load step never jumps.
- On a mode change, ramps power to 0 first, flips the mode, then ramps up.

Parameters:
- N_REQ, 4, number of requesters.
- TICK_DIV, 8, clock cycles per single power step (≥2).
- PWR_W, 4, power field width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  N_REQ  request per requester; held high with stable data until ack.
- req_mode  in  N_REQ  requested mode bit, one per requester.
- req_power  in  N_REQ*PWR_W  requested power; requester i uses bits [i*PWR_W +: PWR_W].
- ack  out  N_REQ  one-cycle grant pulse, registered.
- grant_id  out  clog2(N_REQ)  index of the last granted requester.
- chs_conf  out  8  configuration word: {mode, 3'b000, power}.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle pulse when chs_conf equals the granted target.

Behaviour:
- Reset (async, immediate):
  - chs_conf=8'h00, ack=0, grant_id=0, busy=0, done=0.
  - RR pointer=0, tick counter=0, state=IDLE.
- States: IDLE, RAMP_DOWN, SWITCH, RAMP_UP.
- IDLE grant selection:
  - If any req is high, grant the first set bit scanning from the pointer upward, with wrap.
  - Latch the target mode/power. Pointer becomes (i+1) mod N_REQ. grant_id=i.
  - ack[i] is high for exactly the next cycle, together with the next state.
- Next state after grant:
  - Mode differs, power≠0 → RAMP_DOWN.
  - Mode differs, power=0 → SWITCH.
  - Mode same, power above target → RAMP_DOWN.
  - Mode same, power below target → RAMP_UP.
  - Exact match → stay IDLE, done pulses with ack; chs_conf is unchanged.
- Tick counter:
  - Cleared on entry to any ramp state.
  - Increments each cycle; a power step occurs when counter==TICK_DIV-1, and the counter then wraps to 0.
  - The first step is visible TICK_DIV cycles after the ramp state is entered.
- RAMP_DOWN:
  - Power decrements per step.
  - Reaching 0 with a pending mode change → SWITCH.
  - Reaching the target (same mode) → IDLE with done.
- SWITCH: one cycle. Mode bit is flipped with power=0.
  - Then target=0 → IDLE with done.
  - Otherwise → RAMP_UP.
- RAMP_UP:
  - Power increments per step.
  - Reaching the target → IDLE with done, in the same cycle the final value appears.
- Power stays within 0..2^PWR_W-1 and never overshoots the target. Bits 6:4 of chs_conf are always 0.
- Requests while busy:
  - Not acknowledged; they are evaluated in IDLE after done.
  - A req dropped before ack is lost; no queueing.
  - A req still high after its ack (data unchanged) counts as a new request and resolves as an exact match.
- Reset mid-ramp: chs_conf goes to 0 without ramping; the in-flight grant is abandoned and no done is issued.

Decomposition:
- Package chs_pkg holds:
  - CONF_W=8, MODE_BIT=7, PWR_LSB=0, PWR_W=4.
  - State encoding localparams.
  - Function building the conf word from mode/power.
- Sub-module rr_arbiter (N_REQ parameter): req vector and pointer in, one-hot grant and index out, purely combinational. The pointer register lives in the sequencer.

Test Plan:
1. Reset: rst_n low mid-simulation → chs_conf=8'h00, busy=0, ack=0 asynchronously, before the next clk edge.
2. Ramp up (TICK_DIV=8), from 8'h00, req[0] with mode 0 / power 3 at cycle G:
   - ack[0] high at G+1.
   - chs_conf goes 8'h01, 8'h02, 8'h03 at G+9, G+17, G+25.
   - done at G+25, busy low at G+26.
3. Mode change, from 8'h02, request mode 1 / power 1:
   - chs_conf sequence is 8'h01, 8'h00, 8'h80, 8'h81.
   - 8'h80 lasts exactly one cycle after 8'h00 is reached + TICK_DIV, and never shows power>0 with the old mode after the flip.
4. Round robin, pointer 0:
   - req[0] and req[2] together → grant 0, then grant 2.
   - Then req[0] and req[1] → grant 0 (pointer=3 wraps), then grant 1.
5. Exact match: chs_conf=8'h85 and a request for mode 1 / power 5 → ack and done in the same cycle, busy stays 0, chs_conf unchanged.
6. Reset mid-ramp, during RAMP_UP at 8'h02 → chs_conf=8'h00, no done. After release, a fresh request ramps from 8'h00.

Source files
------------

// File: rtl/chs_pkg.sv
// Shared definitions for the channel-configuration sequencer: word layout,
// state encoding and the helper that packs mode/power into the config word.
package chs_pkg;

    localparam int CONF_W   = 8;
    localparam int MODE_BIT = 7;
    localparam int PWR_LSB  = 0;
    localparam int PWR_W    = 4;

    localparam logic [1:0] ST_IDLE_ENC      = 2'd0;
    localparam logic [1:0] ST_RAMP_DOWN_ENC = 2'd1;
    localparam logic [1:0] ST_SWITCH_ENC    = 2'd2;
    localparam logic [1:0] ST_RAMP_UP_ENC   = 2'd3;

    typedef enum logic [1:0] {
        IDLE      = ST_IDLE_ENC,
        RAMP_DOWN = ST_RAMP_DOWN_ENC,
        SWITCH    = ST_SWITCH_ENC,
        RAMP_UP   = ST_RAMP_UP_ENC
    } state_e;

    // Unused bits between the mode bit and the power field are always zero.
    function automatic logic [CONF_W-1:0] build_conf(input logic mode,
                                                     input logic [PWR_W-1:0] power);
        logic [CONF_W-1:0] word;
        word = '0;
        word[MODE_BIT] = mode;
        word[PWR_LSB +: PWR_W] = power;
        return word;
    endfunction

endpackage

// File: rtl/chs_conf_sequencer_if.sv
// Requester-side handshake bundle: request vector with per-requester
// mode/power data, and the registered grant pulse plus granted index.
interface chs_conf_sequencer_if #(
    parameter int N_REQ = 4,
    parameter int PWR_W = chs_pkg::PWR_W
);

    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]       req;
    logic [N_REQ-1:0]       req_mode;
    logic [N_REQ*PWR_W-1:0] req_power;
    logic [N_REQ-1:0]       ack;
    logic [ID_W-1:0]        grant_id;

    modport master (
        output req, req_mode, req_power,
        input  ack, grant_id
    );

    modport slave (
        input  req, req_mode, req_power,
        output ack, grant_id
    );

endinterface

// File: rtl/chs_conf_sequencer_rr_arbiter.sv
// Combinational round-robin picker: returns the first asserted request at or
// above the pointer, wrapping around. The pointer itself is owned by the caller.
module rr_arbiter #(
    parameter  int N_REQ = 4,
    localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_idx,
    output logic             valid
);

    logic [N_REQ-1:0] rotated;
    logic [ID_W:0]    sum;

    // Rotate so the pointer sits at bit 0, take the lowest set bit, then map back.
    always_comb begin
        rotated   = N_REQ'({req, req} >> ptr);
        valid     = 1'b0;
        sum       = '0;
        grant     = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rotated[k]) begin
                valid = 1'b1;
                sum   = {1'b0, ptr} + (ID_W + 1)'(k);
            end
        end
        if (sum >= (ID_W + 1)'(N_REQ)) begin
            sum = sum - (ID_W + 1)'(N_REQ);
        end
        grant_idx = sum[ID_W-1:0];
        if (valid) begin
            grant = N_REQ'(1) << grant_idx;
        end
    end

endmodule

// File: rtl/chs_conf_sequencer.sv
// Shares one channel-configuration word among several requesters. Grants
// round-robin, then walks the power field one step per tick toward the target,
// dropping to zero before any mode flip so the load never jumps.
module chs_conf_sequencer
    import chs_pkg::*;
#(
    parameter  int N_REQ    = 4,
    parameter  int TICK_DIV = 8,
    parameter  int PWR_W    = chs_pkg::PWR_W,
    localparam int ID_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int CNT_W    = $clog2(TICK_DIV)
) (
    input  logic               clk,
    input  logic               rst_n,
    chs_conf_sequencer_if.slave bus,
    output logic [CONF_W-1:0]  chs_conf,
    output logic               busy,
    output logic               done
);

    state_e           state_q, state_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tgt_mode_q, tgt_mode_d;
    logic [PWR_W-1:0] tgt_pwr_q, tgt_pwr_d;
    logic             mode_q, mode_d;
    logic [PWR_W-1:0] pwr_q, pwr_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic [ID_W-1:0]  grant_id_q, grant_id_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [N_REQ-1:0] arb_grant;
    logic [ID_W-1:0]  arb_idx;
    logic             arb_valid;
    logic             sel_mode;
    logic [PWR_W-1:0] sel_pwr;
    logic [PWR_W-1:0] pwr_inc;
    logic [PWR_W-1:0] pwr_dec;
    logic             tick;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arb (
        .req       (bus.req),
        .ptr       (ptr_q),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .valid     (arb_valid)
    );

    assign pwr_inc = pwr_q + PWR_W'(1);
    assign pwr_dec = pwr_q - PWR_W'(1);
    assign tick    = (cnt_q == CNT_W'(TICK_DIV - 1));

    // Pick out the mode/power carried by the one-hot winner.
    always_comb begin
        sel_mode = 1'b0;
        sel_pwr  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (arb_grant[k]) begin
                sel_mode = bus.req_mode[k];
                sel_pwr  = bus.req_power[k*PWR_W +: PWR_W];
            end
        end
    end

    // Next-state logic for grant, ramp stepping and the mode switch.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        tgt_mode_d = tgt_mode_q;
        tgt_pwr_d  = tgt_pwr_q;
        mode_d     = mode_q;
        pwr_d      = pwr_q;
        ack_d      = '0;
        grant_id_d = grant_id_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    ack_d      = arb_grant;
                    grant_id_d = arb_idx;
                    ptr_d      = (arb_idx == ID_W'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;
                    tgt_mode_d = sel_mode;
                    tgt_pwr_d  = sel_pwr;
                    cnt_d      = '0;
                    if (sel_mode != mode_q) begin
                        state_d = (pwr_q != '0) ? RAMP_DOWN : SWITCH;
                    end else if (pwr_q > sel_pwr) begin
                        state_d = RAMP_DOWN;
                    end else if (pwr_q < sel_pwr) begin
                        state_d = RAMP_UP;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end

            RAMP_DOWN: begin
                if (tick) begin
                    cnt_d = '0;
                    pwr_d = pwr_dec;
                    if (tgt_mode_q != mode_q) begin
                        if (pwr_dec == '0) begin
                            state_d = SWITCH;
                        end
                    end else if (pwr_dec == tgt_pwr_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            SWITCH: begin
                mode_d = ~mode_q;
                pwr_d  = '0;
                cnt_d  = '0;
                if (tgt_pwr_q == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = RAMP_UP;
                end
            end

            RAMP_UP: begin
                if (tick) begin
                    cnt_d = '0;
                    pwr_d = pwr_inc;
                    if (pwr_inc == tgt_pwr_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Busy covers every non-idle cycle and lingers through the done cycle.
        busy_d = (state_d != IDLE) || (state_q != IDLE);
    end

    // State and registered outputs; reset drops the word to zero at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            cnt_q      <= '0;
            tgt_mode_q <= 1'b0;
            tgt_pwr_q  <= '0;
            mode_q     <= 1'b0;
            pwr_q      <= '0;
            ack_q      <= '0;
            grant_id_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            tgt_mode_q <= tgt_mode_d;
            tgt_pwr_q  <= tgt_pwr_d;
            mode_q     <= mode_d;
            pwr_q      <= pwr_d;
            ack_q      <= ack_d;
            grant_id_q <= grant_id_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign chs_conf     = build_conf(mode_q, pwr_q);
    assign busy         = busy_q;
    assign done         = done_q;
    assign bus.ack      = ack_q;
    assign bus.grant_id = grant_id_q;

endmodule

// File: tb/tb_chs_conf_sequencer.sv
// Directed bench for the configuration sequencer: ramp up/down, mode switch,
// round-robin order, exact-match grants and asynchronous reset behaviour.
module tb_chs_conf_sequencer;

    logic clk;
    logic rst_n;
    logic [7:0] chs_conf;
    logic busy;
    logic done;
    int checks;
    int failures;

    chs_conf_sequencer_if #(.N_REQ(4), .PWR_W(4)) bus ();

    chs_conf_sequencer #(
        .N_REQ    (4),
        .TICK_DIV (8),
        .PWR_W    (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .chs_conf (chs_conf),
        .busy     (busy),
        .done     (done)
    );

    // 10-time-unit clock; inputs change and outputs are sampled on the falling edge.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic applyStimulus(input logic [3:0] reqV, input logic [3:0] modeV,
                                 input logic [15:0] pwrV);
        bus.req       = reqV;
        bus.req_mode  = modeV;
        bus.req_power = pwrV;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] expConf,
                               input logic [3:0] expAck, input logic [1:0] expGid,
                               input logic expBusy, input logic expDone);
        checks++;
        assert (chs_conf === expConf) else begin
            failures++;
            $error("[TB] FAIL %s.chs_conf observed=%h expected=%h", tag, chs_conf, expConf);
        end
        checks++;
        assert (bus.ack === expAck) else begin
            failures++;
            $error("[TB] FAIL %s.ack observed=%b expected=%b", tag, bus.ack, expAck);
        end
        checks++;
        assert (bus.grant_id === expGid) else begin
            failures++;
            $error("[TB] FAIL %s.grant_id observed=%0d expected=%0d", tag, bus.grant_id, expGid);
        end
        checks++;
        assert (busy === expBusy) else begin
            failures++;
            $error("[TB] FAIL %s.busy observed=%b expected=%b", tag, busy, expBusy);
        end
        checks++;
        assert (done === expDone) else begin
            failures++;
            $error("[TB] FAIL %s.done observed=%b expected=%b", tag, done, expDone);
        end
    endtask

    // Linear directed sequence; every expected value below is worked out by hand.
    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        applyStimulus(4'b0000, 4'b0000, 16'h0000);

        waitCycles(2);
        checkOutput("reset_hold", 8'h00, 4'b0000, 2'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        waitCycles(1);
        checkOutput("idle_after_reset", 8'h00, 4'b0000, 2'd0, 1'b0, 1'b0);

        // Ramp 0x00 -> 0x03 from requester 0; steps every 8 cycles.
        applyStimulus(4'b0001, 4'b0000, 16'h0003);
        waitCycles(1);
        checkOutput("ru_ack", 8'h00, 4'b0001, 2'd0, 1'b1, 1'b0);
        applyStimulus(4'b0000, 4'b0000, 16'h0000);
        waitCycles(7);
        checkOutput("ru_hold", 8'h00, 4'b0000, 2'd0, 1'b1, 1'b0);
        waitCycles(1);
        checkOutput("ru_step1", 8'h01, 4'b0000, 2'd0, 1'b1, 1'b0);
        waitCycles(8);
        checkOutput("ru_step2", 8'h02, 4'b0000, 2'd0, 1'b1, 1'b0);
        waitCycles(8);
        checkOutput("ru_final", 8'h03, 4'b0000, 2'd0, 1'b1, 1'b1);
        waitCycles(1);
        checkOutput("ru_idle", 8'h03, 4'b0000, 2'd0, 1'b0, 1'b0);

        // Same-mode ramp down 0x03 -> 0x02 from requester 2 (pointer was 1).
        applyStimulus(4'b0100, 4'b0000, 16'h0200);
        waitCycles(1);
        checkOutput("rd_ack", 8'h03, 4'b0100, 2'd2, 1'b1, 1'b0);
        applyStimulus(4'b0000, 4'b0000, 16'h0000);
        waitCycles(8);
        checkOutput("rd_final", 8'h02, 4'b0000, 2'd2, 1'b1, 1'b1);
        waitCycles(1);
        checkOutput("rd_idle", 8'h02, 4'b0000, 2'd2, 0, 1'b0);

        // Mode change 0x02 -> mode 1 / power 1: 01, 00, 80 (one switch cycle), 81.
        applyStimulus(4'b1000, 4'b1000, 16'h1000);
        waitCycles(1);
        checkOutput("mc_ack", 8'h02, 4'b1000, 2'd3, 1'b1, 1'b0);
        applyStimulus(4'b0000, 4'b0000, 16'h0000);
        waitCycles(8);
        checkOutput("mc_down1", 8'h01, 4'b0000, 2'd3, 1'b1, 1'b0);
        waitCycles(8);
        checkOutput("mc_zero", 8'h00, 4'b0000, 2'd3, 1'b1, 1'b0);
        waitCycles(1);
        checkOutput("mc_flip", 8'h80, 4'b0000, 2'd3, 1'b1, 1'b0);
        waitCycles(7);
        checkOutput("mc_flip_hold", 8'h80, 4'b0000, 2'd3, 1'b1, 1'b0);
        waitCycles(1);
        checkOutput("mc_up1", 8'h81, 4'b0000, 2'd3, 1'b1, 1'b1);
        waitCycles(1);
        checkOutput("mc_idle", 8'h81, 4'b0000, 2'd3, 1'b0, 1'b0);

        // Bring the word to 0x85 (pointer wrapped to 0, so requester 0 wins).
        applyStimulus(4'b0001, 4'b0001, 16'h0005);
        waitCycles(1);
        checkOutput("up85_ack", 8'h81, 4'b0001, 2'd0, 1'b1, 1'b0);
        applyStimulus(4'b0000, 4'b0000, 16'h0000);
        waitCycles(24);
        checkOutput("up85_mid", 8'h84, 4'b0000, 2'd0, 1'b1, 1'b0);
        waitCycles(8);
        checkOutput("up85_final", 8'h85, 4'b0000, 2'd0, 1'b1, 1'b1);
        waitCycles(1);
        checkOutput("up85_idle", 8'h85, 4'b0000, 2'd0, 1'b0, 1'b0);

        // Exact match: ack and done together, busy never rises, word unchanged.
        applyStimulus(4'b0010, 4'b0010, 16'h0050);
        waitCycles(1);
        checkOutput("em_ack", 8'h85, 4'b0010, 2'd1, 1'b0, 1'b1);
        applyStimulus(4'b0000, 4'b0000, 16'h0000);
        waitCycles(1);
        checkOutput("em_after", 8'h85, 4'b0000, 2'd1, 1'b0, 1'b0);
        applyStimulus(4'b0100, 4'b0100, 16'h0500);
        waitCycles(1);
        checkOutput("em2_ack", 8'h85, 4'b0100, 2'd2, 1'b0, 1'b1);

        // Asynchronous reset while ack/done are high: clears before the next edge.
        #1 rst_n = 1'b0;
        #1 checkOutput("rst_async", 8'h00, 4'b0000, 2'd0, 1'b0, 1'b0);
        applyStimulus(4'b0000, 4'b0000, 16'h0000);
        waitCycles(1);
        checkOutput("rst_held", 8'h00, 4'b0000, 2'd0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Reset in the middle of a ramp at 0x02: no done, word to zero.
        applyStimulus(4'b0001, 4'b0000, 16'h0005);
        waitCycles(1);
        checkOutput("rm_ack", 8'h00, 4'b0001, 2'd0, 1'b1, 1'b0);
        applyStimulus(4'b0000, 4'b0000, 16'h0000);
        waitCycles(16);
        checkOutput("rm_at2", 8'h02, 4'b0000, 2'd0, 1'b1, 1'b0);
        waitCycles(3);
        #2 rst_n = 1'b0;
        #1 checkOutput("rm_rst", 8'h00, 4'b0000, 2'd0, 1'b0, 1'b0);
        waitCycles(1);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            waitCycles(1);
            checkOutput("rm_no_done", 8'h00, 4'b0000, 2'd0, 1'b0, 1'b0);
        end

        // Fresh request after reset ramps from 0x00 (pointer 0, only req 3 set).
        applyStimulus(4'b1000, 4'b0000, 16'h1000);
        waitCycles(1);
        checkOutput("fr_ack", 8'h00, 4'b1000, 2'd3, 1'b1, 1'b0);
        applyStimulus(4'b0000, 4'b0000, 16'h0000);
        waitCycles(7);
        checkOutput("fr_hold", 8'h00, 4'b0000, 2'd3, 1'b1, 1'b0);
        waitCycles(1);
        checkOutput("fr_final", 8'h01, 4'b0000, 2'd3, 1'b1, 1'b1);
        waitCycles(1);
        checkOutput("fr_idle", 8'h01, 4'b0000, 2'd3, 1'b0, 1'b0);

        // Round robin from pointer 0 using exact-match requests for 0x01.
        applyStimulus(4'b0101, 4'b0000, 16'h0101);
        waitCycles(1);
        checkOutput("rr_g0", 8'h01, 4'b0001, 2'd0, 1'b0, 1'b1);
        applyStimulus(4'b0100, 4'b0000, 16'h0100);
        waitCycles(1);
        checkOutput("rr_g2", 8'h01, 4'b0100, 2'd2, 1'b0, 1'b1);
        applyStimulus(4'b0000, 4'b0000, 16'h0000);
        waitCycles(1);
        checkOutput("rr_none", 8'h01, 4'b0000, 2'd2, 1'b0, 1'b0);
        applyStimulus(4'b0011, 4'b0000, 16'h0011);
        waitCycles(1);
        checkOutput("rr_wrap0", 8'h01, 4'b0001, 2'd0, 1'b0, 1'b1);
        applyStimulus(4'b0010, 4'b0000, 16'h0010);
        waitCycles(1);
        checkOutput("rr_g1", 8'h01, 4'b0010, 2'd1, 1'b0, 1'b1);

        // Request left high after its ack is granted again as an exact match.
        waitCycles(1);
        checkOutput("hold_rematch", 8'h01, 4'b0010, 2'd1, 1'b0, 1'b1);
        applyStimulus(4'b0000, 4'b0000, 16'h0000);
        waitCycles(1);
        checkOutput("rr_end", 8'h01, 4'b0000, 2'd1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
